// File: rtl/four_core_sched_pkg.sv
// rtl/four_core_sched_pkg.sv - shared types and constants for the four-core job scheduler
package four_core_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } core_state_t;

  localparam int DEF_N_CORES  = 4;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_RESULT_W = 32;
  localparam int DEF_TAG_W    = 4;
  localparam int JOBS_DONE_W  = 16;

  // Round-robin pointer advance: the slot after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/four_core_scheduler_if.sv
// rtl/four_core_scheduler_if.sv - job and result stream handshake bundle for the scheduler
interface four_core_scheduler_if
  import four_core_sched_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RESULT_W = DEF_RESULT_W,
  parameter int TAG_W    = DEF_TAG_W
);

  logic                job_valid;
  logic                job_ready;
  logic [TAG_W-1:0]    job_tag;
  logic [DATA_W-1:0]   job_data;

  logic                res_valid;
  logic                res_ready;
  logic [TAG_W-1:0]    res_tag;
  logic [RESULT_W-1:0] res_data;

  modport master (
    output job_valid, job_tag, job_data, res_ready,
    input  job_ready, res_valid, res_tag, res_data
  );

  modport slave (
    input  job_valid, job_tag, job_data, res_ready,
    output job_ready, res_valid, res_tag, res_data
  );

endinterface

// File: rtl/four_core_scheduler_rr_arbiter.sv
// rtl/four_core_scheduler_rr_arbiter.sv - round-robin arbiter: first request at or after the pointer wins
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             found
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/four_core_scheduler.sv
// rtl/four_core_scheduler.sv - dispatches jobs to free cores round-robin and returns tagged results
module four_core_scheduler
  import four_core_sched_pkg::*;
#(
  parameter int N_CORES  = DEF_N_CORES,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RESULT_W = DEF_RESULT_W,
  parameter int TAG_W    = DEF_TAG_W
) (
  input  logic                        clock,
  input  logic                        reset,
  four_core_scheduler_if.slave        bus,
  output logic [N_CORES-1:0]          core_start,
  output logic [N_CORES*DATA_W-1:0]   core_operand,
  input  logic [N_CORES-1:0]          core_done,
  input  logic [N_CORES*RESULT_W-1:0] core_result,
  output logic [N_CORES-1:0]          busy_mask,
  output logic [JOBS_DONE_W-1:0]      jobs_done
);

  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  core_state_t         state      [N_CORES];
  core_state_t         state_next [N_CORES];
  logic [TAG_W-1:0]    tag_q      [N_CORES];
  logic [DATA_W-1:0]   operand_q  [N_CORES];
  logic [RESULT_W-1:0] result_q   [N_CORES];

  logic [N_CORES-1:0]  idle_vec;
  logic [N_CORES-1:0]  hold_vec;
  logic [N_CORES-1:0]  done_ok;
  logic [N_CORES-1:0]  disp_grant;
  logic [N_CORES-1:0]  coll_grant;
  logic [IDX_W-1:0]    disp_ptr;
  logic [IDX_W-1:0]    coll_ptr;
  logic [IDX_W-1:0]    disp_idx;
  logic [IDX_W-1:0]    coll_idx;
  logic                disp_found;
  logic                coll_found;

  logic                active;
  logic                job_fire;
  logic                res_fire;
  logic                out_load;
  logic                out_valid;
  logic [TAG_W-1:0]    out_tag;
  logic [RESULT_W-1:0] out_data;

  // A done pulse in the start cycle belongs to no job yet, so it is dropped.
  always_comb begin
    idle_vec = '0;
    hold_vec = '0;
    done_ok  = '0;
    for (int k = 0; k < N_CORES; k++) begin
      idle_vec[k] = (state[k] == IDLE);
      hold_vec[k] = (state[k] == HOLD);
      done_ok[k]  = (state[k] == RUN) && core_done[k] && !core_start[k];
    end
  end

  rr_arbiter #(.N(N_CORES), .IDX_W(IDX_W)) u_disp_arb (
    .req       (idle_vec),
    .ptr       (disp_ptr),
    .grant     (disp_grant),
    .grant_idx (disp_idx),
    .found     (disp_found)
  );

  rr_arbiter #(.N(N_CORES), .IDX_W(IDX_W)) u_coll_arb (
    .req       (hold_vec),
    .ptr       (coll_ptr),
    .grant     (coll_grant),
    .grant_idx (coll_idx),
    .found     (coll_found)
  );

  // job_ready stays low until the first edge after reset so every output reads 0 in reset.
  assign bus.job_ready = active && disp_found;
  assign job_fire      = bus.job_valid && bus.job_ready;
  assign res_fire      = out_valid && bus.res_ready;
  assign out_load      = (!out_valid || bus.res_ready) && coll_found;

  always_comb begin
    for (int k = 0; k < N_CORES; k++) begin
      state_next[k] = state[k];
      case (state[k])
        IDLE:    if (job_fire && disp_grant[k]) state_next[k] = RUN;
        RUN:     if (done_ok[k])                 state_next[k] = HOLD;
        HOLD:    if (out_load && coll_grant[k])  state_next[k] = IDLE;
        default: state_next[k] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_CORES; k++) begin
        state[k]     <= IDLE;
        tag_q[k]     <= '0;
        operand_q[k] <= '0;
        result_q[k]  <= '0;
      end
      core_start <= '0;
      busy_mask  <= '0;
    end else begin
      for (int k = 0; k < N_CORES; k++) begin
        state[k]     <= state_next[k];
        busy_mask[k] <= (state_next[k] != IDLE);
        if (job_fire && disp_grant[k]) begin
          tag_q[k]     <= bus.job_tag;
          operand_q[k] <= bus.job_data;
        end
        if (done_ok[k]) begin
          result_q[k] <= core_result[k*RESULT_W +: RESULT_W];
        end
      end
      core_start <= job_fire ? disp_grant : '0;
    end
  end

  // Single output register; reload on the handshake cycle keeps results back-to-back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active    <= 1'b0;
      disp_ptr  <= '0;
      coll_ptr  <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
      jobs_done <= '0;
    end else begin
      active <= 1'b1;
      if (job_fire) begin
        disp_ptr <= IDX_W'(wrap_inc(int'(disp_idx), N_CORES));
      end
      if (out_load) begin
        out_valid <= 1'b1;
        out_tag   <= tag_q[coll_idx];
        out_data  <= result_q[coll_idx];
        coll_ptr  <= IDX_W'(wrap_inc(int'(coll_idx), N_CORES));
      end else if (res_fire) begin
        out_valid <= 1'b0;
      end
      if (res_fire) begin
        jobs_done <= jobs_done + JOBS_DONE_W'(1);
      end
    end
  end

  always_comb begin
    core_operand = '0;
    for (int k = 0; k < N_CORES; k++) begin
      core_operand[k*DATA_W +: DATA_W] = operand_q[k];
    end
  end

  assign bus.res_valid = out_valid;
  assign bus.res_tag   = out_tag;
  assign bus.res_data  = out_data;

endmodule

// File: doc/four_core_scheduler.md
Name: four_core_scheduler

Overview:
Job scheduler that sits between the AXI register front end and the four compute cores. It accepts jobs on a valid/ready stream and dispatches each one to a free core using round-robin selection. It collects core results through a round-robin result arbiter and returns them, tagged, on a valid/ready result stream. It also exposes the occupancy of each core and a count of completed jobs for status registers.

Parameters:
N_CORES, 4, number of cores managed
DATA_W, 32, job operand width
RESULT_W, 32, core result width
TAG_W, 4, job tag width, carried from job to result unchanged

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high reset
job_valid  in  1  job offered
job_ready  out  1  scheduler can accept a job this cycle
job_tag  in  TAG_W  job identifier
job_data  in  DATA_W  job operand
core_start  out  N_CORES  one-cycle start pulse per core
core_operand  out  N_CORES*DATA_W  operand per core, held stable while that core is RUN
core_done  in  N_CORES  one-cycle completion pulse per core
core_result  in  N_CORES*RESULT_W  result per core, valid while its core_done is high
res_valid  out  1  result available
res_ready  in  1  result consumed
res_tag  out  TAG_W  tag of the job that produced the result
res_data  out  RESULT_W  result value
busy_mask  out  N_CORES  bit k set when core k is not IDLE
jobs_done  out  16  count of completed result handshakes

Behaviour:
- Reset values: every output is 0; all cores IDLE; both round-robin pointers at 0; output stage empty. Reset asserts asynchronously and is released synchronously. A reset mid-operation discards all in-flight jobs and held results; the cores share the same reset.
- Per-core state machine:
  - IDLE -> RUN on dispatch.
  - RUN -> HOLD on core_done. The result and the stored tag are captured into a per-core buffer.
  - HOLD -> IDLE when the output stage loads from that core.
- Dispatch:
  - job_ready = (any core IDLE), combinational from registered state.
  - On a handshake at cycle t, the selected core is the first IDLE core at or after the dispatch pointer. Its tag and operand are registered; it enters RUN at t+1 and core_start[k] is high only at t+1.
  - The dispatch pointer then moves to k+1 mod N_CORES.
- core_done[k] is honoured only when core k is RUN and core_start[k] is low, so the earliest honoured pulse is at t+2. Pulses in any other state or cycle are ignored.
- Collection:
  - The output stage is a single register. It loads when it is empty or when res_valid && res_ready, provided at least one core is HOLD.
  - The grant goes to the first HOLD core at or after the collect pointer. The pointer then moves to grant+1 mod N_CORES.
  - A handshake and a reload in the same cycle give back-to-back results with no bubble.
  - While res_valid && !res_ready, res_tag and res_data are stable.
- Latency: a core_done at cycle d makes the core HOLD at d+1 and gives res_valid at d+2 (output stage free, core granted). A core released at cycle r can be dispatched at r+1, never in the same cycle.
- busy_mask is registered from the state vector.
- jobs_done increments on each result handshake and wraps from 16'hFFFF to 0.

Decomposition:
- Package four_core_sched_pkg: core_state_t enum {IDLE, RUN, HOLD}, default width constants, and the jobs_done width constant.
- Sub-module rr_arbiter (N requests, pointer input, one-hot grant plus grant index). It is instantiated twice: once for dispatch over IDLE cores and once for collection over HOLD cores.

Test Plan:
1. Reset release -> job_ready=1, res_valid=0, busy_mask=4'b0000, jobs_done=0, core_start=0.
2. Four back-to-back jobs with tags 1..4 and data 0xA0..0xA3 -> core_start pulses on cores 0,1,2,3 in consecutive cycles with matching operands; busy_mask=4'b1111; job_ready=0; a fifth job waits until the first core is released.
3. core_done on cores 3 and 1 in the same cycle with results 0x33 and 0x11, collect pointer 0 -> results out in order (tag 2, 0x11) then (tag 4, 0x33), back-to-back with res_ready=1; jobs_done=2.
4. res_ready held low for 10 cycles while res_valid=1 -> res_tag and res_data stable; other finished cores stay HOLD; a core freed once res_ready goes high is dispatchable the next cycle.
5. reset asserted between clock edges while cores 0 and 1 are RUN -> all outputs 0 immediately; after release, the next job is dispatched to core 0.
6. 65536 completed jobs -> jobs_done wraps to 0 on the final handshake; scheduling is unaffected.
